// File: rtl/spi_receiver.sv
// spi_receiver: slave-side receiver for the one-way LED-strip SPI link, MSB-first bytes into a one-deep valid/ack buffer.
// Optional zero-byte frame-start detector enabled by defining SPI_RX_START_FRAME_EN.
module spi_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic       spi_clk,
    input  logic       spi_reset_n,
    input  logic       spi_input_data,
    input  logic       spi_input_clock,
    output logic [7:0] spi_rx_data,
    output logic       spi_rx_valid,
    input  logic       spi_rx_ack,
    output logic       spi_rx_overrun,
    output logic       spi_rx_timeout,
    output logic       spi_rx_busy
`ifdef SPI_RX_START_FRAME_EN
    ,
    output logic       spi_rx_frame_start
`endif
);
    typedef enum logic {STATE_IDLE = 1'b0, STATE_RECEIVE = 1'b1} state_t;
    state_t                   r_state, w_state_next;
    logic [SYNC_STAGES-1:0]   r_clk_sync, r_data_sync;
    logic                     r_clk_hist;
    logic [7:0]               r_shift;
    logic [2:0]               r_bit_cnt;
    logic [TIMEOUT_WIDTH-1:0] r_tmo_cnt;
    logic                     r_done, r_timeout, r_valid, r_overrun;
    logic [7:0]               r_data;
    logic                     w_clk_s, w_data_s, w_rise, w_done, w_tmo;
    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_rise   = w_clk_s & ~r_clk_hist;
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            STATE_IDLE: w_state_next = w_rise ? STATE_RECEIVE : STATE_IDLE;
            STATE_RECEIVE: begin
                if (w_rise) begin
                    w_done       = (r_bit_cnt == 3'd7);
                    w_state_next = w_done ? STATE_IDLE : STATE_RECEIVE;
                end else if (r_tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    w_tmo        = 1'b1;
                    w_state_next = STATE_IDLE;
                end
            end
            default: w_state_next = STATE_IDLE;
        endcase
    end
    // Delivery uses the registered done so the full byte is already in r_shift.
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_state     <= STATE_IDLE;
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_hist  <= 1'b0;
            r_shift     <= 8'd0;
            r_bit_cnt   <= 3'd0;
            r_tmo_cnt   <= '0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_data      <= 8'd0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], spi_input_clock};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_input_data};
            r_clk_hist  <= w_clk_s;
            r_state     <= w_state_next;
            r_done      <= w_done;
            r_timeout   <= w_tmo;
            if (w_rise)
                r_shift <= {r_shift[6:0], w_data_s};
            r_bit_cnt <= (w_state_next == STATE_IDLE) ? 3'd0 : w_rise ? r_bit_cnt + 3'd1 : r_bit_cnt;
            r_tmo_cnt <= (r_state != STATE_RECEIVE || w_rise || w_tmo) ? '0 : r_tmo_cnt + 1'b1;
            if (r_done) begin
                if (!r_valid || spi_rx_ack) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (spi_rx_ack) begin
                r_valid <= 1'b0;
            end
        end
    end
`ifdef SPI_RX_START_FRAME_EN
    logic [1:0] r_zero_cnt;
    logic       r_frame_start;
    always_ff @(posedge spi_clk or negedge spi_reset_n) begin
        if (!spi_reset_n) begin
            r_zero_cnt    <= 2'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tmo) begin
                r_zero_cnt <= 2'd0;
            end else if (r_done) begin
                if (r_shift != 8'd0)
                    r_zero_cnt <= 2'd0;
                else if (r_zero_cnt == 2'd3)
                    r_frame_start <= 1'b1;
                else
                    r_zero_cnt <= r_zero_cnt + 2'd1;
            end
        end
    end
    assign spi_rx_frame_start = r_frame_start;
`endif
    assign spi_rx_data    = r_data;
    assign spi_rx_valid   = r_valid;
    assign spi_rx_overrun = r_overrun;
    assign spi_rx_timeout = r_timeout;
    assign spi_rx_busy    = (r_bit_cnt != 3'd0);
endmodule
